// File: rtl/irq_pending_ctrl.sv
// Pending-interrupt register with a two-state offer FSM feeding a downstream priority encoder.
// Define IRQ_EDGE_DETECT_EN for rising-edge event detection; level detection otherwise.
module irq_pending_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    output logic [3:0] req_vec,
    output logic       req_valid,
    input  logic [1:0] grant_id,
    input  logic       grant_ack,
    output logic [3:0] pending,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(ACK_TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] irq_s_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] req_vec_q, req_vec_d;
    logic       req_valid_q, req_valid_d;
    logic       timeout_err_q, timeout_err_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] event_vec;
    logic [3:0] clr_vec;
    logic       ack_valid;

    // irq_in is registered once before detection, so a pending bit appears one edge after sampling.
`ifdef IRQ_EDGE_DETECT_EN
    logic [3:0] irq_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_s_q;
        end
    end

    assign event_vec = irq_s_q & ~irq_prev_q;
`else
    assign event_vec = irq_s_q;
`endif

    always_comb begin
        state_d       = state_q;
        req_vec_d     = req_vec_q;
        req_valid_d   = req_valid_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
        clr_vec       = '0;
        ack_valid     = (state_q == OFFER) && grant_ack && req_vec_q[grant_id];

        if (ack_valid) begin
            clr_vec[grant_id] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if ((pending_q & mask) != 4'b0000) begin
                    state_d     = OFFER;
                    req_vec_d   = pending_q & mask;
                    req_valid_d = 1'b1;
                    timer_d     = '0;
                end
            end
            OFFER: begin
                // A valid ack wins over a timeout landing on the same edge.
                if (ack_valid) begin
                    state_d     = IDLE;
                    req_vec_d   = '0;
                    req_valid_d = 1'b0;
                end else if (timer_q == TIMEOUT_VAL) begin
                    state_d       = IDLE;
                    req_vec_d     = '0;
                    req_valid_d   = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new event on a bit being cleared keeps that bit set.
        pending_d = (pending_q & ~clr_vec) | event_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            irq_s_q       <= '0;
            pending_q     <= '0;
            req_vec_q     <= '0;
            req_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            irq_s_q       <= irq_in;
            pending_q     <= pending_d;
            req_vec_q     <= req_vec_d;
            req_valid_q   <= req_valid_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    assign req_vec     = req_vec_q;
    assign req_valid   = req_valid_q;
    assign pending     = pending_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomized and directed bench for irq_pending_ctrl against a behavioural model.
// Honours IRQ_EDGE_DETECT_EN the same way as the design.
module tb_irq_pending_ctrl;

    localparam int TMO = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic [3:0] req_vec;
    logic       req_valid;
    logic [1:0] grant_id;
    logic       grant_ack;
    logic [3:0] pending;
    logic       timeout_err;

    int total;
    int bad;
    int err_seen;
    int offers_seen;
    logic last_valid;

    // Model state: the last two irq_in samples plus the offer as seen from outside.
    logic [3:0] m_s1, m_s2;
    logic [3:0] m_pend;
    logic       m_offering;
    logic [3:0] m_vec;
    int         m_age;
    logic       m_err;

    irq_pending_ctrl #(.ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask       (mask),
        .req_vec    (req_vec),
        .req_valid  (req_valid),
        .grant_id   (grant_id),
        .grant_ack  (grant_ack),
        .pending    (pending),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input logic rstn, input logic [3:0] irq, input logic [3:0] msk,
                             input logic [1:0] gid, input logic ack);
        logic [3:0] ev;
        logic [3:0] nxt;
        if (!rstn) begin
            m_s1 = '0; m_s2 = '0; m_pend = '0;
            m_offering = 1'b0; m_vec = '0; m_age = 0; m_err = 1'b0;
            return;
        end
`ifdef IRQ_EDGE_DETECT_EN
        ev = m_s1 & ~m_s2;
`else
        ev = m_s1;
`endif
        nxt = m_pend;
        m_err = 1'b0;
        if (m_offering) begin
            if (ack && m_vec[gid]) begin
                nxt[gid] = 1'b0;
                m_offering = 1'b0;
                m_vec = '0;
            end else if (m_age == TMO) begin
                m_err = 1'b1;
                m_offering = 1'b0;
                m_vec = '0;
            end else begin
                m_age++;
            end
        end else if ((m_pend & msk) != 0) begin
            m_offering = 1'b1;
            m_vec = m_pend & msk;
            m_age = 0;
        end
        m_pend = nxt | ev;
        m_s2 = m_s1;
        m_s1 = irq;
    endtask

    task automatic applyStimulus(input logic rstn, input logic [3:0] irq, input logic [3:0] msk,
                                 input logic [1:0] gid, input logic ack);
        rst_n = rstn; irq_in = irq; mask = msk; grant_id = gid; grant_ack = ack;
        @(posedge clk);
        modelStep(rstn, irq, msk, gid, ack);
        #2;
        checkOutput("pending", 8'(pending), 8'(m_pend));
        checkOutput("req_vec", 8'(req_vec), 8'(m_vec));
        checkOutput("req_valid", 8'(req_valid), 8'(m_offering));
        checkOutput("timeout_err", 8'(timeout_err), 8'(m_err));
        if (timeout_err === 1'b1) err_seen++;
        if (req_valid === 1'b1 && last_valid !== 1'b1) offers_seen++;
        last_valid = req_valid;
    endtask

    // Acknowledge whatever the model says is on offer until everything is serviced.
    task automatic drainPending();
        logic [1:0] g;
        logic       a;
        for (int i = 0; i < 24; i++) begin
            g = 2'd0;
            a = 1'b0;
            if (m_offering) begin
                for (int b = 0; b < 4; b++) if (m_vec[b]) g = 2'(b);
                a = 1'b1;
            end
            applyStimulus(1'b1, 4'b0000, 4'b1111, g, a);
        end
    endtask

    initial begin
        logic [3:0] r_irq, r_mask;
        logic [1:0] r_gid;
        logic       r_ack, r_rst;
        int         err_base;

        total = 0; bad = 0; err_seen = 0; offers_seen = 0; last_valid = 1'b0;
        m_s1 = '0; m_s2 = '0; m_pend = '0; m_offering = 1'b0; m_vec = '0; m_age = 0; m_err = 1'b0;
        rst_n = 1'b0; irq_in = 4'b1111; mask = 4'b1111; grant_id = 2'd0; grant_ack = 1'b0;

        $display("[TB] reset with all lines high");
        applyStimulus(1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0);
        checkOutput("rst_pending", 8'(pending), 8'h00);
        checkOutput("rst_valid", 8'(req_valid), 8'h00);

        $display("[TB] single request");
        applyStimulus(1'b1, 4'b0100, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        checkOutput("single_valid", 8'(req_valid), 8'h01);
        checkOutput("single_vec", 8'(req_vec), 8'h04);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd2, 1'b1);
        checkOutput("single_cleared", 8'(pending), 8'h00);
        checkOutput("single_idle", 8'(req_valid), 8'h00);

        $display("[TB] snapshot and masking");
        applyStimulus(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0001, 2'd0, 1'b0);
        checkOutput("snap_vec", 8'(req_vec), 8'h01);
        applyStimulus(1'b1, 4'b0000, 4'b0011, 2'd0, 1'b0);
        checkOutput("snap_hold", 8'(req_vec), 8'h01);
        applyStimulus(1'b1, 4'b0000, 4'b0011, 2'd0, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0011, 2'd0, 1'b0);
        checkOutput("snap_next", 8'(req_vec), 8'h02);
        applyStimulus(1'b1, 4'b0000, 4'b0011, 2'd1, 1'b1);

        $display("[TB] bogus ack");
        applyStimulus(1'b1, 4'b1000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b1);
        checkOutput("bogus_valid", 8'(req_valid), 8'h01);
        checkOutput("bogus_pending", 8'(pending), 8'h08);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd3, 1'b1);
        checkOutput("bogus_cleared", 8'(pending), 8'h00);

        $display("[TB] timeout");
        err_base = err_seen;
        applyStimulus(1'b1, 4'b0010, 4'b1111, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        checkOutput("tmo_pulses", 8'(err_seen - err_base), 8'h01);
        checkOutput("tmo_pending", 8'(pending), 8'h02);
        checkOutput("tmo_idle", 8'(req_valid), 8'h00);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        checkOutput("tmo_reoffer", 8'(req_valid), 8'h01);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd1, 1'b1);

        $display("[TB] set wins over clear");
        applyStimulus(1'b1, 4'b0010, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 4'b1111, 2'd1, 1'b1);
        checkOutput("setwins_pending", 8'(pending), 8'h02);
        checkOutput("setwins_idle", 8'(req_valid), 8'h00);
        drainPending();

        $display("[TB] held line");
        offers_seen = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'b0001, 4'b1111, 2'd0, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b1);
`ifdef IRQ_EDGE_DETECT_EN
        checkOutput("held_offers", 8'(offers_seen), 8'h01);
`else
        checkOutput("held_reoffered", 8'(offers_seen > 1), 8'h01);
`endif
        drainPending();

        $display("[TB] reset during offer");
        applyStimulus(1'b1, 4'b0100, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b1111, 2'd2, 1'b1);
        checkOutput("rstmid_valid", 8'(req_valid), 8'h00);
        checkOutput("rstmid_pending", 8'(pending), 8'h00);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            r_irq  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            r_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : mask;
            r_ack  = ($urandom_range(0, 2) == 0);
            r_gid  = 2'($urandom);
            if (m_offering && $urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 4; b++) if (m_vec[b]) r_gid = 2'(b);
            end
            r_rst = ($urandom_range(0, 99) != 0);
            applyStimulus(r_rst, r_irq, r_mask, r_gid, r_ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
